// File: rtl/pavan_handshake_pulse_src_ctrl_pkg.sv
// Shared types and constants for the handshake pulse source controller.
package pavan_handshake_pulse_src_ctrl_pkg;

    // Controller state encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        GUARD     = 3'd4
    } state_t;

    // Default pending counter width and the deepest queue it can hold.
    localparam int CNT_W_DEFAULT = 4;
    localparam int PEND_MAX      = (1 << CNT_W_DEFAULT) - 1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pavan_sat_updown_cnt.sv
// Saturating up/down counter: never wraps in either direction; an increment
// that arrives while full (with no matching decrement) is dropped and flagged.
module pavan_sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk_a,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         drop
);

    assign full = &cnt;
    // A coincident decrement frees a slot, so only a lone increment at full is lost.
    assign drop = inc & ~dec & full;

    // Count update; inc and dec together cancel out.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/pavan_handshake_pulse_src_ctrl.sv
// Transmit-side controller for the handshake pulse synchronizer: queues local
// events and issues them one at a time, tracking each busy rise/fall handshake.
module pavan_handshake_pulse_src_ctrl
    import pavan_handshake_pulse_src_ctrl_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int GUARD_CYCLES = 1,
    parameter int RISE_TO      = 4
) (
    input  logic             clk_a,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             busy_in,
    input  logic             clr_err,
    output logic             pulse_out,
    output logic             tx_done,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             lost,
    output logic             idle
);

    localparam int TO_W = cnt_width(RISE_TO);
    localparam int G_W  = cnt_width(GUARD_CYCLES);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RISE_TO);
    localparam logic [G_W-1:0]  G_LOAD  = G_W'(GUARD_CYCLES);

    state_t          state, state_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [G_W-1:0]  g_cnt, g_cnt_n;
    logic            pulse_n, done_n, lost_set, deq;
    logic            pend_full, pend_drop, ovf_set;

    pavan_sat_updown_cnt #(.W(CNT_W)) u_pend_cnt (
        .clk_a (clk_a),
        .rst_n (rst_n),
        .inc   (evt_in),
        .dec   (deq),
        .cnt   (pending),
        .full  (pend_full),
        .drop  (pend_drop)
    );

    assign ovf_set = pend_full & pend_drop;
    assign idle    = (state == IDLE) && (pending == '0);

    // Next-state, counter and strobe decode; dequeue only from IDLE with busy low.
    always_comb begin
        state_n  = state;
        to_cnt_n = to_cnt;
        g_cnt_n  = g_cnt;
        pulse_n  = 1'b0;
        done_n   = 1'b0;
        lost_set = 1'b0;
        deq      = 1'b0;
        case (state)
            IDLE: begin
                if ((pending != '0) && !busy_in) begin
                    deq     = 1'b1;
                    pulse_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n  = WAIT_RISE;
                to_cnt_n = TO_LOAD;
            end
            WAIT_RISE: begin
                if (busy_in) begin
                    state_n = WAIT_FALL;
                end else if (to_cnt <= TO_W'(1)) begin
                    // Timed out; the dequeued event is abandoned, not re-queued.
                    to_cnt_n = '0;
                    lost_set = 1'b1;
                    state_n  = GUARD;
                    g_cnt_n  = G_LOAD;
                end else begin
                    to_cnt_n = to_cnt - TO_W'(1);
                end
            end
            WAIT_FALL: begin
                if (!busy_in) begin
                    done_n = 1'b1;
                    if (GUARD_CYCLES > 0) begin
                        state_n = GUARD;
                        g_cnt_n = G_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            GUARD: begin
                if (g_cnt <= G_W'(1)) begin
                    g_cnt_n = '0;
                    state_n = IDLE;
                end else begin
                    g_cnt_n = g_cnt - G_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters, registered strobes and sticky flags (set beats clear).
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            to_cnt    <= '0;
            g_cnt     <= '0;
            pulse_out <= 1'b0;
            tx_done   <= 1'b0;
            overflow  <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_n;
            to_cnt    <= to_cnt_n;
            g_cnt     <= g_cnt_n;
            pulse_out <= pulse_n;
            tx_done   <= done_n;
            overflow  <= ovf_set | (overflow & ~clr_err);
            lost      <= lost_set | (lost & ~clr_err);
        end
    end

endmodule

// File: tb/tb_pavan_handshake_pulse_src_ctrl.sv
// Bench for the handshake pulse source controller: two instances (deep and
// shallow queue) share event/clear inputs; each has its own synchronizer model.
module tb_pavan_handshake_pulse_src_ctrl;

    localparam int GUARD   = 1;
    localparam int RISE_TO = 4;

    logic clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    logic       rst_n, evt, clr, busy0, busy1;
    logic       pulse0, pulse1, done0, done1, ovf0, ovf1, lost0, lost1, idle0, idle1;
    logic [3:0] pend0;
    logic [1:0] pend1;

    pavan_handshake_pulse_src_ctrl #(.CNT_W(4), .GUARD_CYCLES(GUARD), .RISE_TO(RISE_TO)) dut0 (
        .clk_a(clk_a), .rst_n(rst_n), .evt_in(evt), .busy_in(busy0), .clr_err(clr),
        .pulse_out(pulse0), .tx_done(done0), .pending(pend0), .overflow(ovf0),
        .lost(lost0), .idle(idle0));

    pavan_handshake_pulse_src_ctrl #(.CNT_W(2), .GUARD_CYCLES(GUARD), .RISE_TO(RISE_TO)) dut1 (
        .clk_a(clk_a), .rst_n(rst_n), .evt_in(evt), .busy_in(busy1), .clr_err(clr),
        .pulse_out(pulse1), .tx_done(done1), .pending(pend1), .overflow(ovf1),
        .lost(lost1), .idle(idle1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: queue depth plus a timeline of the transfer in flight.
    int pmax[2] = '{15, 3};
    int m_pend[2], m_tiss[2], m_tready[2];
    bit m_inflight[2], m_risen[2], m_pulse[2], m_done[2], m_ovf[2], m_lost[2];

    // Synchronizer responder state.
    bit force_mode, force_val, no_rise;
    int rs[2], rc[2];
    int npulse0, ndone0, last_done;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_tiss[i] = 0; m_tready[i] = 0;
            m_inflight[i] = 0; m_risen[i] = 0; m_pulse[i] = 0;
            m_done[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
        end
        last_done = -1;
    endtask

    // Consume the inputs of cycle 'cyc' and produce the outputs seen in cycle cyc+1.
    task automatic model_step(input int i, input bit e, input bit c, input bit b);
        bit deq, lset, oset;
        deq = 0; lset = 0; oset = 0;
        m_pulse[i] = 0;
        m_done[i]  = 0;
        if (!m_inflight[i]) begin
            if (cyc >= m_tready[i] && m_pend[i] > 0 && !b) begin
                deq = 1; m_pulse[i] = 1; m_inflight[i] = 1; m_risen[i] = 0; m_tiss[i] = cyc;
            end
        end else if (cyc > m_tiss[i] + 1) begin
            if (!m_risen[i]) begin
                if (b) m_risen[i] = 1;
                else if (cyc == m_tiss[i] + 1 + RISE_TO) begin
                    lset = 1; m_inflight[i] = 0;
                    m_tready[i] = cyc + 1 + ((GUARD > 1) ? GUARD : 1);
                end
            end else if (!b) begin
                m_done[i] = 1; m_inflight[i] = 0; m_tready[i] = cyc + 1 + GUARD;
            end
        end
        if (e && !deq) begin
            if (m_pend[i] == pmax[i]) oset = 1;
            else m_pend[i]++;
        end else if (deq && !e) begin
            m_pend[i]--;
        end
        m_ovf[i]  = oset | (m_ovf[i] & !c);
        m_lost[i] = lset | (m_lost[i] & !c);
    endtask

    task automatic compare_all();
        bit ei0, ei1;
        ei0 = !m_inflight[0] && cyc >= m_tready[0] && m_pend[0] == 0;
        ei1 = !m_inflight[1] && cyc >= m_tready[1] && m_pend[1] == 0;
        chk("d0.pulse", pulse0, m_pulse[0]);  chk("d1.pulse", pulse1, m_pulse[1]);
        chk("d0.done", done0, m_done[0]);     chk("d1.done", done1, m_done[1]);
        chk("d0.pend", pend0, m_pend[0]);     chk("d1.pend", pend1, m_pend[1]);
        chk("d0.ovf", ovf0, m_ovf[0]);        chk("d1.ovf", ovf1, m_ovf[1]);
        chk("d0.lost", lost0, m_lost[0]);     chk("d1.lost", lost1, m_lost[1]);
        chk("d0.idle", idle0, ei0);           chk("d1.idle", idle1, ei1);
    endtask

    // Synchronizer: busy rises 1..3 cycles after a pulse, stays high 1..6 cycles.
    task automatic responder(input int i);
        bit p, b;
        p = (i == 0) ? pulse0 : pulse1;
        b = (i == 0) ? busy0 : busy1;
        case (rs[i])
            0: if (p && !no_rise) begin rs[i] = 1; rc[i] = $urandom_range(1, 3); end
            1: begin rc[i]--; if (rc[i] == 0) begin b = 1; rs[i] = 2; rc[i] = $urandom_range(1, 6); end end
            default: begin rc[i]--; if (rc[i] == 0) begin b = 0; rs[i] = 0; end end
        endcase
        if (i == 0) busy0 = b; else busy1 = b;
    endtask

    task automatic release_busy();
        force_mode = 0; busy0 = 0; busy1 = 0; rs[0] = 0; rs[1] = 0;
    endtask

    task automatic step(input bit e, input bit c);
        bit b0, b1;
        evt = e; clr = c;
        if (force_mode) begin busy0 = force_val; busy1 = force_val; end
        b0 = busy0; b1 = busy1;
        @(posedge clk_a); #1;
        if (rst_n) begin
            model_step(0, e, c, b0);
            model_step(1, e, c, b1);
        end else begin
            model_reset();
        end
        cyc++;
        compare_all();
        if (pulse0 && last_done >= 0) chk("d0.gap_after_done", 8'((cyc - last_done) >= GUARD + 1), 8'd1);
        if (pulse0) npulse0++;
        if (done0) begin ndone0++; last_done = cyc; end
        if (!force_mode) begin responder(0); responder(1); end
    endtask

    initial begin
        int p_snap, d_snap;
        rst_n = 0; evt = 0; clr = 0; busy0 = 0; busy1 = 0;
        force_mode = 0; force_val = 0; no_rise = 0;
        rs[0] = 0; rs[1] = 0; rc[0] = 0; rc[1] = 0;
        npulse0 = 0; ndone0 = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_a);
        #1;
        compare_all();
        rst_n = 1;

        // Single event: pending at edge 1, pulse at edge 2, full handshake
        step(1, 0);
        chk("lat.pend_edge1", pend0, 8'd1);
        step(0, 0);
        chk("lat.pulse_edge2", pulse0, 8'd1);
        repeat (20) step(0, 0);
        chk("single.done_count", 8'(ndone0), 8'd1);
        chk("single.idle", idle0, 8'd1);

        // Five events queued while busy held high, then drained
        force_mode = 1; force_val = 1;
        repeat (5) step(1, 0);
        chk("queue.pend5", pend0, 8'd5);
        repeat (5) step(0, 0);
        p_snap = npulse0; d_snap = ndone0;
        release_busy();
        repeat (80) step(0, 0);
        chk("queue.pulses", 8'(npulse0 - p_snap), 8'd5);
        chk("queue.dones", 8'(ndone0 - d_snap), 8'd5);

        // Saturation on the shallow instance; clear and set together keeps the flag
        force_mode = 1; force_val = 1;
        repeat (5) step(1, 0);
        chk("sat.pend_full", pend1, 8'd3);
        chk("sat.overflow", ovf1, 8'd1);
        step(1, 1);
        chk("sat.clr_vs_set", ovf1, 8'd1);
        step(0, 1);
        chk("sat.cleared", ovf1, 8'd0);
        // Event at full coincident with a dequeue is accepted without overflow
        release_busy();
        step(1, 0);
        chk("sat.deq_evt_pend", pend1, 8'd3);
        chk("sat.deq_evt_ovf", ovf1, 8'd0);
        repeat (100) step(0, 0);

        // busy never rises: lost after timeout, next event still issued
        no_rise = 1;
        step(1, 0);
        step(1, 0);
        p_snap = npulse0;
        repeat (20) step(0, 0);
        chk("lost.flag", lost0, 8'd1);
        chk("lost.next_issued", 8'(npulse0 - p_snap), 8'd1);
        step(0, 1);
        no_rise = 0;
        repeat (10) step(0, 0);

        // Event coincident with the IDLE dequeue at pending=1
        step(1, 0);
        step(1, 0);
        chk("coinc.pend", pend0, 8'd1);
        chk("coinc.pulse", pulse0, 8'd1);
        repeat (40) step(0, 0);

        // Async reset during WAIT_FALL with busy still high
        force_mode = 1; force_val = 0;
        step(1, 0);
        step(0, 0);
        force_val = 1;
        repeat (3) step(0, 0);
        step(1, 0);
        #3 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        step(0, 0);
        rst_n = 1;
        p_snap = npulse0;
        step(1, 0);
        repeat (5) step(0, 0);
        chk("rst.no_pulse_busy", 8'(npulse0 - p_snap), 8'd0);
        release_busy();
        repeat (4) step(0, 0);
        chk("rst.pulse_after_fall", 8'(npulse0 - p_snap), 8'd1);
        repeat (15) step(0, 0);

        // Randomized traffic with occasional lost handshakes
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 63) == 0) no_rise = !no_rise;
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        no_rise = 0;
        repeat (150) step(0, 0);
        chk("final.idle0", idle0, 8'd1);
        chk("final.idle1", idle1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
